// File: rtl/yarp_operand_fetch.sv
// Operand-fetch/issue stage: reads the register file, bypasses same-cycle writeback,
// tracks pending writers in a scoreboard and holds one instruction toward execute.
module yarp_operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  input  logic            rs1_en_i,
  input  logic            rs2_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            rd_wen_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [AW-1:0]   rf_rs1_addr_o,
  output logic [AW-1:0]   rf_rs2_addr_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [AW-1:0]   ex_rd_addr_o,
  output logic            ex_rd_wen_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_pc_o
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic            wb_clr_rs1;
  logic            wb_clr_rs2;
  logic            wb_clr_rd;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rf_rs1_addr_o = rs1_addr_i;
  assign rf_rs2_addr_o = rs2_addr_i;

  // A writeback landing this cycle resolves the hazard because its value is bypassed.
  assign wb_clr_rs1 = wb_en_i && (wb_addr_i == rs1_addr_i);
  assign wb_clr_rs2 = wb_en_i && (wb_addr_i == rs2_addr_i);
  assign wb_clr_rd  = wb_en_i && (wb_addr_i == rd_addr_i);

  assign hazard = (rs1_en_i && pend[rs1_addr_i] && !wb_clr_rs1)
               || (rs2_en_i && pend[rs2_addr_i] && !wb_clr_rs2)
               || (rd_wen_i && (rd_addr_i != '0) && pend[rd_addr_i] && !wb_clr_rd);

  assign dec_ready_o = !hazard && (!ex_valid_o || ex_ready_i) && !flush_i;
  assign accept      = dec_valid_i && dec_ready_o;

  always_comb begin
    op1 = rf_rs1_data_i;
    if (rs1_addr_i == '0)
      op1 = '0;
    else if (wb_en_i && (wb_addr_i == rs1_addr_i))
      op1 = wb_data_i;
  end

  always_comb begin
    op2 = rf_rs2_data_i;
    if (rs2_addr_i == '0)
      op2 = '0;
    else if (wb_en_i && (wb_addr_i == rs2_addr_i))
      op2 = wb_data_i;
  end

  // Order matters: a new writer's set overrides a same-cycle writeback clear.
  always_comb begin
    pend_nxt = pend;
    if (wb_en_i)
      pend_nxt[wb_addr_i] = 1'b0;
    if (accept && rd_wen_i && (rd_addr_i != '0))
      pend_nxt[rd_addr_i] = 1'b1;
    if (flush_i && ex_valid_o && ex_rd_wen_o)
      pend_nxt[ex_rd_addr_o] = 1'b0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend         <= '0;
      ex_valid_o   <= 1'b0;
      ex_op1_o     <= '0;
      ex_op2_o     <= '0;
      ex_rd_addr_o <= '0;
      ex_rd_wen_o  <= 1'b0;
      ex_imm_o     <= '0;
      ex_pc_o      <= '0;
    end else begin
      pend <= pend_nxt;
      if (accept) begin
        ex_valid_o   <= 1'b1;
        ex_op1_o     <= op1;
        ex_op2_o     <= op2;
        ex_rd_addr_o <= rd_addr_i;
        ex_rd_wen_o  <= rd_wen_i;
        ex_imm_o     <= imm_i;
        ex_pc_o      <= pc_i;
      end else if (ex_ready_i || flush_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_yarp_operand_fetch.sv
// Directed bench for yarp_operand_fetch: issue, hazards, bypass, x0, backpressure, flush, reset.
module tb_yarp_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        rs1_en_i, rs2_en_i, rd_wen_i;
  logic [31:0] imm_i, pc_i;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o;
  logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] ex_op1_o, ex_op2_o, ex_imm_o, ex_pc_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_wen_o;

  int tests = 0;
  int fails = 0;

  yarp_operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_en_i(rs1_en_i), .rs2_en_i(rs2_en_i),
    .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .imm_i(imm_i), .pc_i(pc_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wen_o(ex_rd_wen_o),
    .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    dec_valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rs1_en_i = 0; rs2_en_i = 0;
    rd_addr_i = 0; rd_wen_i = 0; imm_i = 0; pc_i = 0;
    rf_rs1_data_i = 0; rf_rs2_data_i = 0;
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0; flush_i = 0; ex_ready_i = 1;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc);
    dec_valid_i = 1; rs1_addr_i = rs1; rs2_addr_i = rs2; rs1_en_i = 1; rs2_en_i = 1;
    rd_addr_i = rd; rd_wen_i = wen; rf_rs1_data_i = d1; rf_rs2_data_i = d2;
    imm_i = imm; pc_i = pc;
  endtask

  // Retire a pending register with a bare writeback cycle.
  task automatic drain_wb(input logic [4:0] a);
    @(negedge clk); idle(); wb_en_i = 1; wb_addr_i = a; wb_data_i = 32'hCAFE;
    @(posedge clk); #1;
    @(negedge clk); idle();
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ex_valid_o); end
    tests++; if (ex_op1_o !== 32'h0 || ex_pc_o !== 32'h0) begin fails++; $display("FAIL reset_data op1=%h pc=%h exp=0", ex_op1_o, ex_pc_o); end
    tests++; if (dut.pend !== 32'h0) begin fails++; $display("FAIL reset_pend got=%h exp=0", dut.pend); end
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_plain_issue();
    @(negedge clk); idle(); instr(5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22, 32'h100, 32'h40);
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL plain_ready got=%b exp=1", dec_ready_o); end
    tests++; if (rf_rs1_addr_o !== 5'd3 || rf_rs2_addr_o !== 5'd4) begin fails++; $display("FAIL plain_rfaddr got=%0d/%0d exp=3/4", rf_rs1_addr_o, rf_rs2_addr_o); end
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1) begin fails++; $display("FAIL plain_valid got=%b exp=1", ex_valid_o); end
    tests++; if (ex_op1_o !== 32'h11 || ex_op2_o !== 32'h22) begin fails++; $display("FAIL plain_ops got=%h/%h exp=11/22", ex_op1_o, ex_op2_o); end
    tests++; if (ex_rd_addr_o !== 5'd5 || ex_rd_wen_o !== 1'b1 || ex_imm_o !== 32'h100 || ex_pc_o !== 32'h40) begin
      fails++; $display("FAIL plain_meta rd=%0d wen=%b imm=%h pc=%h exp=5/1/100/40", ex_rd_addr_o, ex_rd_wen_o, ex_imm_o, ex_pc_o); end
    tests++; if (dut.pend !== 32'h0000_0020) begin fails++; $display("FAIL plain_pend got=%h exp=00000020", dut.pend); end
  endtask

  task automatic test_raw_bypass();
    // x5 is still pending from the plain issue.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); instr(5'd5, 5'd0, 5'd6, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h44);
      #1;
      tests++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL raw_stall cyc=%0d got=%b exp=0", i, dec_ready_o); end
      @(posedge clk);
    end
    @(negedge clk); wb_en_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'hDEAD;
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL raw_release got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1 || ex_op1_o !== 32'hDEAD) begin fails++; $display("FAIL raw_bypass valid=%b op1=%h exp=1/dead", ex_valid_o, ex_op1_o); end
    tests++; if (dut.pend !== 32'h0000_0040) begin fails++; $display("FAIL raw_pend got=%h exp=00000040", dut.pend); end
    drain_wb(5'd6);
  endtask

  task automatic test_x0();
    @(negedge clk); idle(); instr(5'd0, 5'd3, 5'd0, 1'b1, 32'hFFFF, 32'h77, 32'h0, 32'h48);
    wb_en_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'h55;
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL x0_ready got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (ex_op1_o !== 32'h0 || ex_op2_o !== 32'h77) begin fails++; $display("FAIL x0_ops got=%h/%h exp=0/77", ex_op1_o, ex_op2_o); end
    tests++; if (dut.pend !== 32'h0) begin fails++; $display("FAIL x0_pend got=%h exp=0", dut.pend); end
    @(negedge clk); idle(); instr(5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h4C);
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL x0_nostall got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    @(negedge clk); idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk); idle(); instr(5'd1, 5'd2, 5'd8, 1'b1, 32'hA, 32'hB, 32'h33, 32'h80);
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1) begin fails++; $display("FAIL bp_valid got=%b exp=1", ex_valid_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); ex_ready_i = 0; instr(5'd10, 5'd12, 5'd11, 1'b1, 32'hC, 32'hD, 32'h44, 32'h84);
      #1;
      tests++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, dec_ready_o); end
      @(posedge clk); #1;
      tests++; if (ex_valid_o !== 1'b1 || ex_op1_o !== 32'hA || ex_op2_o !== 32'hB || ex_imm_o !== 32'h33 || ex_pc_o !== 32'h80 || ex_rd_addr_o !== 5'd8) begin
        fails++; $display("FAIL bp_hold cyc=%0d valid=%b op1=%h op2=%h imm=%h pc=%h rd=%0d", i, ex_valid_o, ex_op1_o, ex_op2_o, ex_imm_o, ex_pc_o, ex_rd_addr_o); end
    end
    @(negedge clk); ex_ready_i = 1;
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL bp_resume got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1 || ex_op1_o !== 32'hC || ex_pc_o !== 32'h84) begin fails++; $display("FAIL bp_next valid=%b op1=%h pc=%h exp=1/c/84", ex_valid_o, ex_op1_o, ex_pc_o); end
    drain_wb(5'd8);
    drain_wb(5'd11);
  endtask

  task automatic test_simultaneous();
    @(negedge clk); idle(); instr(5'd1, 5'd2, 5'd7, 1'b1, 32'h1, 32'h2, 32'h0, 32'h90);
    @(posedge clk); #1;
    @(negedge clk); idle(); instr(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 32'h94);
    rs1_en_i = 0; rs2_en_i = 0;
    wb_en_i = 1; wb_addr_i = 5'd7; wb_data_i = 32'h70;
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL sim_ready got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (dut.pend !== 32'h0000_0080) begin fails++; $display("FAIL sim_pend got=%h exp=00000080", dut.pend); end
    drain_wb(5'd7);
  endtask

  task automatic test_flush();
    @(negedge clk); idle(); instr(5'd1, 5'd2, 5'd9, 1'b1, 32'h1, 32'h2, 32'h0, 32'hA0);
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1 || dut.pend !== 32'h0000_0200) begin fails++; $display("FAIL fl_setup valid=%b pend=%h exp=1/00000200", ex_valid_o, dut.pend); end
    @(negedge clk); idle(); ex_ready_i = 0; flush_i = 1; instr(5'd9, 5'd0, 5'd0, 1'b0, 32'h99, 32'h0, 32'h0, 32'hA4);
    #1;
    tests++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL fl_ready got=%b exp=0", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b0 || dut.pend !== 32'h0) begin fails++; $display("FAIL fl_kill valid=%b pend=%h exp=0/0", ex_valid_o, dut.pend); end
    @(negedge clk); flush_i = 0;
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL fl_reader_ready got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1 || ex_op1_o !== 32'h99) begin fails++; $display("FAIL fl_reader valid=%b op1=%h exp=1/99", ex_valid_o, ex_op1_o); end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); idle(); instr(5'd1, 5'd2, 5'd5, 1'b1, 32'h1, 32'h2, 32'h0, 32'hB0);
    @(posedge clk); #1;
    @(negedge clk); idle(); instr(5'd5, 5'd0, 5'd0, 1'b0, 32'h5A5A, 32'h0, 32'h0, 32'hB4);
    #1;
    tests++; if (dec_ready_o !== 1'b0) begin fails++; $display("FAIL rst_stall got=%b exp=0", dec_ready_o); end
    #1 reset_n = 0;
    #1;
    tests++; if (ex_valid_o !== 1'b0 || dut.pend !== 32'h0) begin fails++; $display("FAIL rst_async valid=%b pend=%h exp=0/0", ex_valid_o, dut.pend); end
    @(negedge clk); reset_n = 1;
    #1;
    tests++; if (dec_ready_o !== 1'b1) begin fails++; $display("FAIL rst_release got=%b exp=1", dec_ready_o); end
    @(posedge clk); #1;
    tests++; if (ex_valid_o !== 1'b1 || ex_op1_o !== 32'h5A5A || ex_pc_o !== 32'hB4) begin fails++; $display("FAIL rst_reissue valid=%b op1=%h pc=%h exp=1/5a5a/b4", ex_valid_o, ex_op1_o, ex_pc_o); end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_plain_issue();
    test_raw_bypass();
    test_x0();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_mid_stall();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/yarp_operand_fetch.md
Name: yarp_operand_fetch

Overview:
- Register-read/issue stage between decode and execute; drives source addresses to the register file, captures operands, and registers them for execute.
- Holds a 32-entry pending-write scoreboard that stalls RAW/WAW hazards.
- Bypasses the same-cycle writeback value, since the register file updates only at the clock edge.
- Valid/ready handshake on both sides; single-entry pipeline register toward execute.

Parameters:
XLEN, 32, datapath width of operands, imm, pc and writeback data
NREG, 32, number of architectural registers; address width is $clog2(NREG)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode presents an instruction
dec_ready_o  out  1  stage accepts the instruction this cycle
rs1_addr_i  in  5  source 1 address
rs2_addr_i  in  5  source 2 address
rs1_en_i  in  1  instruction reads rs1
rs2_en_i  in  1  instruction reads rs2
rd_addr_i  in  5  destination address
rd_wen_i  in  1  instruction writes rd
imm_i  in  XLEN  decoded immediate
pc_i  in  XLEN  instruction PC
rf_rs1_addr_o  out  5  register-file read address 1 (= rs1_addr_i, combinational)
rf_rs2_addr_o  out  5  register-file read address 2 (= rs2_addr_i, combinational)
rf_rs1_data_i  in  XLEN  register-file read data 1 (combinational read)
rf_rs2_data_i  in  XLEN  register-file read data 2
wb_en_i  in  1  writeback commits this cycle (same strobe as register-file write enable)
wb_addr_i  in  5  writeback destination
wb_data_i  in  XLEN  writeback data
flush_i  in  1  kill the instruction held toward execute
ex_valid_o  out  1  operands valid toward execute
ex_ready_i  in  1  execute accepts
ex_op1_o  out  XLEN  resolved rs1 value
ex_op2_o  out  XLEN  resolved rs2 value
ex_rd_addr_o  out  5  destination address
ex_rd_wen_o  out  1  destination write enable
ex_imm_o  out  XLEN  immediate
ex_pc_o  out  XLEN  PC

Behaviour:
- Reset (async, reset_n=0): ex_valid_o=0; all ex_* data outputs = 0; scoreboard pend[31:0]=0. Takes effect immediately, including mid-stall.
- wb_clr[r] = wb_en_i & (wb_addr_i==r).
- Hazard, combinational:
  - (rs1_en_i & pend[rs1] & ~wb_clr[rs1])
  - | (rs2_en_i & pend[rs2] & ~wb_clr[rs2])
  - | (rd_wen_i & rd!=0 & pend[rd] & ~wb_clr[rd]).
- dec_ready_o = ~hazard & (~ex_valid_o | ex_ready_i) & ~flush_i.
- Accept = dec_valid_i & dec_ready_o. Latency is 1: operands appear on ex_* the cycle after accept.
- Operand resolution, combinational, captured on accept, per source:
  - addr==0 → 0;
  - else wb_en_i & wb_addr_i==addr & wb_addr_i!=0 → wb_data_i (bypass);
  - else rf data.
  - Disabled source (rs*_en_i=0) still resolves the same way; the value is don't-care to execute.
- Output register:
  - On accept: load all ex_* and set ex_valid_o=1.
  - Else if ex_ready_i: ex_valid_o=0.
  - Data holds stable while ex_valid_o & ~ex_ready_i.
- Scoreboard, per register r, next-state order:
  - Clear on wb_clr[r].
  - Then set on accept & rd_wen_i & rd_addr_i==r & r!=0. Set wins over a simultaneous clear of the same r.
  - Flush clear: flush_i & ex_valid_o & ex_rd_wen_o clears pend[ex_rd_addr_o] (killed writer never writes back).
  - pend[0] is always 0.
- flush_i: ex_valid_o←0 next cycle; no accept that cycle; ex_* data is don't-care after flush.
- Writeback to x0 is ignored for both bypass and scoreboard.
- No handshake violation: ex_valid_o never drops without ex_ready_i or flush_i.

Test Plan:
- Reset mid-stall: pend[5]=1, dec stalled; assert reset_n=0 → ex_valid_o=0 and pend=0 immediately; after release, the same instruction is accepted next cycle.
- Plain issue: rf x3=0x11, x4=0x22, issue add x5,x3,x4 with ex_ready_i=1 → next cycle ex_op1=0x11, ex_op2=0x22, ex_rd_addr=5, ex_valid=1, pend[5]=1.
- RAW stall then bypass:
  - issue x5 writer; next instruction reads x5 → dec_ready_o=0 for each cycle until wb_en_i=1, wb_addr=5, wb_data=0xDEAD.
  - In that cycle accept occurs and ex_op1=0xDEAD; pend[5]=0.
- x0 rules: rs1=0 with rf_rs1_data_i=0xFFFF and wb_en_i to addr 0 data 0x55 → ex_op1=0; writer to x0 leaves pend=0 and never stalls.
- Backpressure/simultaneous:
  - ex_ready_i=0 with ex_valid_o=1 → dec_ready_o=0 and ex_* stable for 3 cycles.
  - New writer of x7 accepted in the same cycle as wb clear of x7 → pend[7]=1.
- Flush: flush_i with the held instruction writing x9 → ex_valid_o=0, pend[9]=0, dec_ready_o=0 that cycle; a reader of x9 is accepted next cycle without stall.
